// File: rtl/baud_pkg.sv
// Shared constants for the UART baud-tick generator: rate_sel codes, parameter
// defaults and the rate-table divisor function.
package baud_pkg;

    localparam int unsigned OSR_DEFAULT    = 16;
    localparam int unsigned CNT_W_DEFAULT  = 16;
    localparam int unsigned FRAC_W_DEFAULT = 4;
    localparam int unsigned RATE_CODES     = 8;

    localparam logic [2:0] RATE_SEL_DEF    = 3'd0;
    localparam logic [2:0] RATE_SEL_2400   = 3'd1;
    localparam logic [2:0] RATE_SEL_4800   = 3'd2;
    localparam logic [2:0] RATE_SEL_9600   = 3'd3;
    localparam logic [2:0] RATE_SEL_19200  = 3'd4;
    localparam logic [2:0] RATE_SEL_38400  = 3'd5;
    localparam logic [2:0] RATE_SEL_57600  = 3'd6;
    localparam logic [2:0] RATE_SEL_115200 = 3'd7;

    function automatic int unsigned rate_baud(input logic [2:0] code);
        int unsigned baud;
        case (code)
            RATE_SEL_DEF:    baud = 9600;
            RATE_SEL_2400:   baud = 2400;
            RATE_SEL_4800:   baud = 4800;
            RATE_SEL_9600:   baud = 9600;
            RATE_SEL_19200:  baud = 19200;
            RATE_SEL_38400:  baud = 38400;
            RATE_SEL_57600:  baud = 57600;
            RATE_SEL_115200: baud = 115200;
            default:         baud = 9600;
        endcase
        return baud;
    endfunction

    // Divisor scaled by 2^frac_w and rounded to nearest: the bits above frac_w are
    // the integer divisor, the low frac_w bits the fraction.
    function automatic longint unsigned rate_div_scaled(
        input logic [2:0]        code,
        input longint unsigned   clk_hz,
        input int unsigned       osr,
        input int unsigned       frac_w
    );
        longint unsigned num;
        longint unsigned den;
        num = (clk_hz << frac_w) << 1;
        den = 64'(rate_baud(code)) * 64'(osr);
        return ((num / den) + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Integer+fractional clock divider: cycle counter and phase accumulator; os_raw
// marks the edge on which the counter wraps. BAUD_FRAC_EN enables the accumulator.
module baud_frac_div
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter int unsigned FRAC_W = FRAC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              restart,
    input  logic [CNT_W-1:0]  d_int,
    input  logic [FRAC_W-1:0] d_frac,
    output logic              os_raw
);

    localparam logic [CNT_W:0] EFF_ONE = (CNT_W+1)'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   eff;
    logic             carry;
    logic             clear;

    assign clear = !enable || restart;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, d_frac};
    assign carry   = acc_sum[FRAC_W];

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (os_raw) begin
            acc_d = acc_sum[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_d_frac;
    assign unused_d_frac = ^d_frac;
    assign carry         = 1'b0;
`endif

    // eff is one bit wider so a full-scale divisor plus carry cannot wrap.
    always_comb begin
        eff    = {1'b0, d_int} + {{CNT_W{1'b0}}, carry};
        os_raw = !clear && ({1'b0, cnt_q} == (eff - EFF_ONE));
        cnt_d  = cnt_q + CNT_W'(1);
        if (clear || os_raw) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/baud_frac_gen.sv
// UART baud-tick generator: shadowed divisor, oversample counter and registered
// os/mid/bit strobes. Define BAUD_FRAC_EN to enable the fractional divisor.
module baud_frac_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned OSR    = OSR_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter int unsigned FRAC_W = FRAC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sync_restart,
    input  logic [2:0]        rate_sel,
    input  logic              custom_en,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    localparam int unsigned       OS_W      = $clog2(OSR);
    localparam logic [OS_W-1:0]   OS_MID    = OS_W'(OSR / 2);
    localparam logic [CNT_W-1:0]  D_INT_MIN = CNT_W'(2);

    logic [CNT_W-1:0]  tbl_int [RATE_CODES];
    logic [CNT_W-1:0]  src_int;
    logic [CNT_W-1:0]  d_int_q;
    logic [CNT_W-1:0]  d_int_d;
    logic [FRAC_W-1:0] d_frac_act;
    logic [OS_W-1:0]   os_cnt_q;
    logic [OS_W-1:0]   os_cnt_d;
    logic [OS_W-1:0]   os_cnt_inc;
    logic              os_raw;
    logic              bit_edge;
    logic              shadow_load;
    logic              os_tick_q, os_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] tbl_frac [RATE_CODES];
    logic [FRAC_W-1:0] src_frac;
    logic [FRAC_W-1:0] d_frac_q;
    logic [FRAC_W-1:0] d_frac_d;
`endif

    for (genvar g = 0; g < RATE_CODES; g++) begin : g_rate
        localparam longint unsigned SCALED = rate_div_scaled(3'(g), 64'(CLK_HZ), OSR, FRAC_W);
        assign tbl_int[g] = CNT_W'(SCALED >> FRAC_W);
`ifdef BAUD_FRAC_EN
        assign tbl_frac[g] = FRAC_W'(SCALED);
`endif
    end

    always_comb begin
        src_int = custom_en ? div_int : tbl_int[rate_sel];
        if (src_int < D_INT_MIN) begin
            src_int = D_INT_MIN;
        end
        os_cnt_inc  = os_cnt_q + OS_W'(1);
        bit_edge    = os_raw && (os_cnt_inc == '0);
        // Divisor changes land only while idle, on realign, or at a bit boundary.
        shadow_load = !enable || sync_restart || bit_edge;
        d_int_d     = shadow_load ? src_int : d_int_q;

        os_cnt_d = os_cnt_q;
        if (!enable || sync_restart) begin
            os_cnt_d = '0;
        end else if (os_raw) begin
            os_cnt_d = os_cnt_inc;
        end

        os_tick_d  = os_raw;
        mid_tick_d = os_raw && (os_cnt_inc == OS_MID);
        bit_tick_d = bit_edge;
    end

`ifdef BAUD_FRAC_EN
    always_comb begin
        src_frac = custom_en ? div_frac : tbl_frac[rate_sel];
        d_frac_d = shadow_load ? src_frac : d_frac_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_frac_q <= src_frac;
        end else begin
            d_frac_q <= d_frac_d;
        end
    end

    assign d_frac_act = d_frac_q;
`else
    logic unused_div_frac;
    assign unused_div_frac = ^div_frac;
    assign d_frac_act      = '0;
`endif

    baud_frac_div #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .restart (sync_restart),
        .d_int   (d_int_q),
        .d_frac  (d_frac_act),
        .os_raw  (os_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            d_int_q    <= src_int;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            d_int_q    <= d_int_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Self-checking bench for baud_frac_gen: expected tick cycles are queued from the
// divisor arithmetic when stimulus is driven and compared as the DUT strobes.
module tb_baud_frac_gen;

    localparam int unsigned OSR      = 16;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned FRAC_W   = 4;
    localparam int          FRAC_ONE = 16;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b1;
    logic              sync_restart = 1'b0;
    logic [2:0]        rate_sel = 3'd0;
    logic              custom_en = 1'b1;
    logic [CNT_W-1:0]  div_int = 16'd4;
    logic [FRAC_W-1:0] div_frac = 4'd0;
    logic              os_tick, mid_tick, bit_tick;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;

    typedef struct {
        int cyc;
        bit mid;
        bit bt;
    } tick_t;
    tick_t exp_q[$];

    typedef struct {
        bit               cust;
        logic [2:0]       rs;
        logic [CNT_W-1:0] di;
        logic [3:0]       df;
        int               exp_d;
        int               exp_f;
        int               nbits;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    baud_frac_gen #(
        .CLK_HZ (50_000_000),
        .OSR    (OSR),
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sync_restart (sync_restart),
        .rate_sel     (rate_sel),
        .custom_en    (custom_en),
        .div_int      (div_int),
        .div_frac     (div_frac),
        .os_tick      (os_tick),
        .mid_tick     (mid_tick),
        .bit_tick     (bit_tick)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        tick_t t;
        if (os_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("os_tick_unexpected", 1, 0);
            end else begin
                t = exp_q.pop_front();
                check("os_tick_cycle", cyc, t.cyc);
                check("mid_tick_flag", mid_tick, t.mid);
                check("bit_tick_flag", bit_tick, t.bt);
            end
        end else if (mid_tick !== 1'b0 || bit_tick !== 1'b0) begin
            check("stray_mid_bit", {mid_tick, bit_tick}, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // base = cycle of the last edge before counting starts; tick k lands at
    // base + k*d + floor(k*f/16), os count starting from 0 at base.
    task automatic push_ticks(input int base, input int d, input int f, input int n);
        int fe;
        fe = FRAC_ON ? f : 0;
        for (int k = 1; k <= n; k++) begin
            tick_t t;
            t.cyc = base + k * d + (k * fe) / FRAC_ONE;
            t.mid = (k % OSR) == (OSR / 2);
            t.bt  = (k % OSR) == 0;
            exp_q.push_back(t);
        end
    endtask

    task automatic flush_after(input int n);
        while (exp_q.size() > 0 && exp_q[$].cyc > n) void'(exp_q.pop_back());
    endtask

    task automatic drain(input string name);
        int target;
        target = (exp_q.size() > 0) ? exp_q[$].cyc : cyc;
        while (cyc < target) step();
        enable = 1'b0;
        step();
        step();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        check(name, {os_tick, mid_tick, bit_tick}, 0);
    endtask

    // kind: 0 = rst pulse, 1 = enable low for one edge, 2 = sync_restart pulse
    task automatic interrupt_seq(input int kind);
        int n;
        enable    = 1'b0;
        custom_en = 1'b1;
        div_int   = 16'd5;
        div_frac  = 4'd4;
        step();
        step();
        enable = 1'b1;
        push_ticks(cyc, 5, 4, 40);
        repeat (24) step();
        n = cyc;
        flush_after(n);
        case (kind)
            0:       rst = 1'b1;
            1:       enable = 1'b0;
            default: sync_restart = 1'b1;
        endcase
        step();
        rst          = 1'b0;
        enable       = 1'b1;
        sync_restart = 1'b0;
        check_zero(kind == 0 ? "rst_clears" : (kind == 1 ? "enable_low_clears" : "restart_no_tick"));
        push_ticks(cyc, 5, 4, 24);
        drain(kind == 0 ? "rst_resume_drained" : (kind == 1 ? "enable_resume_drained" : "restart_drained"));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 16'd4,    4'd0,  4,    0,  2};
        vecs[1]  = '{1'b1, 3'd0, 16'd4,    4'd8,  4,    8,  2};
        vecs[2]  = '{1'b0, 3'd7, 16'd0,    4'd0,  27,   2,  2};
        vecs[3]  = '{1'b1, 3'd0, 16'd0,    4'd0,  2,    0,  2};
        vecs[4]  = '{1'b1, 3'd0, 16'd1,    4'd5,  2,    5,  1};
        vecs[5]  = '{1'b0, 3'd5, 16'd0,    4'd0,  81,   6,  1};
        vecs[6]  = '{1'b0, 3'd4, 16'd0,    4'd0,  162,  12, 1};
        vecs[7]  = '{1'b0, 3'd6, 16'd0,    4'd0,  54,   4,  1};
        vecs[8]  = '{1'b0, 3'd0, 16'd0,    4'd0,  325,  8,  1};
        vecs[9]  = '{1'b0, 3'd2, 16'd0,    4'd0,  651,  1,  1};
        vecs[10] = '{1'b1, 3'd3, 16'd1000, 4'd15, 1000, 15, 1};

        step();
        step();
        step();
        check_zero("reset_outputs");
        enable = 1'b0;
        rst    = 1'b0;
        step();
        check_zero("idle_outputs");

        for (int i = 0; i < 11; i++) begin
            enable    = 1'b0;
            custom_en = vecs[i].cust;
            rate_sel  = vecs[i].rs;
            div_int   = vecs[i].di;
            div_frac  = vecs[i].df;
            step();
            step();
            step();
            enable = 1'b1;
            push_ticks(cyc, vecs[i].exp_d, vecs[i].exp_f, OSR * vecs[i].nbits);
            drain("vector_drained");
        end

        interrupt_seq(0);
        interrupt_seq(1);
        interrupt_seq(2);

        // Mid-bit rate switch 115200 -> 9600: current bit finishes on the old divisor.
        begin
            int base2;
            enable    = 1'b0;
            custom_en = 1'b0;
            rate_sel  = 3'd7;
            step();
            step();
            enable = 1'b1;
            push_ticks(cyc, 27, 2, OSR);
            base2 = exp_q[$].cyc;
            push_ticks(base2, 325, 8, OSR);
            repeat (200) step();
            rate_sel = 3'd3;
            drain("rate_switch_drained");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
